// File: rtl/debounce_one_shot.sv
// debounce_one_shot
//   Turns a raw, asynchronous, bouncing button/switch into a clean debounced
//   level and a fixed-width one-shot pulse for each accepted press.
//   btn_in is passed through a two-flop synchroniser. A five-state Moore FSM
//   then qualifies both edges with a shared cycle counter.
// Parameters
//   DB_CYCLES     stable synchronised cycles required to accept an edge (>=1)
//   PULSE_CYCLES  width of pulse_out in clk cycles per accepted press (>=1)
// Ports
//   clk        system clock; all logic runs on its rising edge
//   reset      synchronous, active-high reset
//   btn_in     raw asynchronous input; may bounce
//   db_level   debounced level of btn_in
//   pulse_out  high for PULSE_CYCLES cycles after each debounced rising edge
module debounce_one_shot #(
  parameter int unsigned DB_CYCLES    = 16,
  parameter int unsigned PULSE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic db_level,
  output logic pulse_out
);

  localparam int unsigned MAX_CYCLES = (DB_CYCLES > PULSE_CYCLES) ? DB_CYCLES : PULSE_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_LOW   = 3'd0,
    ST_RISE  = 3'd1,
    ST_PULSE = 3'd2,
    ST_HIGH  = 3'd3,
    ST_FALL  = 3'd4
  } state_t;

  logic             s1_q, s1_d;
  logic             btn_sync_q, btn_sync_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchroniser feed.
  always_comb begin
    s1_d       = btn_in;
    btn_sync_d = s1_q;
  end

  // Next-state and Moore output decode.
  // cnt_d defaults to zero. Any state change, and residence in the idle
  // states, therefore clears the counter. The counting states advance it
  // explicitly.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    db_level  = 1'b0;
    pulse_out = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (btn_sync_q) state_d = ST_RISE;
      end
      ST_RISE: begin
        if (!btn_sync_q)          state_d = ST_LOW;
        else if (cnt_q == DB_LAST) state_d = ST_PULSE;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      ST_PULSE: begin
        // The synchronised input is ignored here, so the pulse always runs
        // its full width.
        db_level  = 1'b1;
        pulse_out = 1'b1;
        if (cnt_q == PULSE_LAST) state_d = ST_HIGH;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      ST_HIGH: begin
        db_level = 1'b1;
        if (!btn_sync_q) state_d = ST_FALL;
      end
      ST_FALL: begin
        db_level = 1'b1;
        if (btn_sync_q)            state_d = ST_HIGH;
        else if (cnt_q == DB_LAST) state_d = ST_LOW;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      default: begin
        state_d = ST_LOW;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= 1'b0;
      btn_sync_q <= 1'b0;
      state_q    <= ST_LOW;
      cnt_q      <= '0;
    end else begin
      s1_q       <= s1_d;
      btn_sync_q <= btn_sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_debounce_one_shot.sv
module tb_debounce_one_shot;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_in = 1'b1;
  logic db_level;
  logic pulse_out;

  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct {
    logic  rst;
    logic  btn;
    logic  exp_db;
    logic  exp_pulse;
    string tag;
  } vec_t;

  vec_t vecs[$];

  debounce_one_shot #(
    .DB_CYCLES   (4),
    .PULSE_CYCLES(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .db_level (db_level),
    .pulse_out(pulse_out)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic btn, input logic db, input logic p,
                     input int unsigned n, input string tag);
    vec_t v;
    v.rst = rst; v.btn = btn; v.exp_db = db; v.exp_pulse = p; v.tag = tag;
    for (int unsigned i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // The inputs are driven on the falling edge. The outputs are checked 1 time
  // unit after the next rising edge.
  task automatic step(input logic rst, input logic btn, input logic db, input logic p,
                      input string tag);
    @(negedge clk);
    reset  = rst;
    btn_in = btn;
    @(posedge clk);
    #1;
    tests++;
    if ({db_level, pulse_out} !== {db, p}) begin
      fails++;
      $display("FAIL %s (check %0d): db_level=%b pulse_out=%b, required db_level=%b pulse_out=%b",
               tag, tests, db_level, pulse_out, db, p);
    end
  endtask

  task automatic steps(input logic rst, input logic btn, input logic db, input logic p,
                       input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) step(rst, btn, db, p, tag);
  endtask

  initial begin
    // Reset with btn high, then the press held through reset release.
    add(1, 1, 0, 0, 3,  "reset");
    add(0, 1, 0, 0, 6,  "press_wait");
    add(0, 1, 1, 1, 2,  "press_pulse");
    add(0, 1, 1, 0, 22, "press_held");
    // Release bounce from the high state: two low samples, then back high.
    add(0, 0, 1, 0, 2,  "rel_bounce_low");
    add(0, 1, 1, 0, 6,  "rel_bounce_high");
    // Clean release.
    add(0, 0, 1, 0, 6,  "release_wait");
    add(0, 0, 0, 0, 6,  "release_done");
    // A three-cycle glitch from idle is filtered.
    add(0, 1, 0, 0, 3,  "glitch_high");
    add(0, 0, 0, 0, 8,  "glitch_after");

    foreach (vecs[i]) step(vecs[i].rst, vecs[i].btn, vecs[i].exp_db, vecs[i].exp_pulse, vecs[i].tag);

    // Press bounce 1,1,0,0,1,1,0,0, then steady high from edge k.
    // A single pulse follows, after edges k+6 and k+7.
    steps(0, 1, 0, 0, 2, "bounce_1a");
    steps(0, 0, 0, 0, 2, "bounce_0a");
    steps(0, 1, 0, 0, 2, "bounce_1b");
    steps(0, 0, 0, 0, 2, "bounce_0b");
    steps(0, 1, 0, 0, 6, "bounce_wait");
    steps(0, 1, 1, 1, 2, "bounce_pulse");
    steps(0, 1, 1, 0, 4, "bounce_held");
    steps(0, 0, 1, 0, 6, "bounce_rel_wait");
    steps(0, 0, 0, 0, 4, "bounce_rel_done");

    // Reset asserted mid-pulse truncates the pulse.
    // After release the held button counts as a new press.
    steps(0, 1, 0, 0, 6, "rst_mid_wait");
    step (0, 1, 1, 1,    "rst_mid_pulse");
    steps(1, 1, 0, 0, 2, "rst_mid_reset");
    steps(0, 1, 0, 0, 6, "rst_post_wait");
    steps(0, 1, 1, 1, 2, "rst_post_pulse");
    steps(0, 1, 1, 0, 3, "rst_post_held");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
